// File: rtl/data_inf_arb_pkg.sv
// Shared types for the rotating-priority stream arbiter: FSM states and index width helper.
package data_inf_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_inf_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first asserted req at or after ptr, wrapping NUM-1 -> 0.
// Purely combinational; no latency, no backpressure.
module rr_pick
    import data_inf_arb_pkg::*;
#(
    parameter int NUM = 4,
    localparam int IW = IDX_W(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic           any,
    output logic [IW-1:0]  idx
);

    always_comb begin
        int          j;
        logic [IW-1:0] w_j;
        any = 1'b0;
        idx = '0;
        j   = 0;
        w_j = '0;
        // Walk from the farthest offset back to ptr so the nearest hit is written last.
        for (int k = NUM - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM) begin
                j = j - NUM;
            end
            w_j = IW'(j);
            if (req[w_j]) begin
                any = 1'b1;
                idx = w_j;
            end
        end
    end

endmodule

// File: rtl/data_inf_rr_arbiter.sv
// Merges NUM valid/ready streams round-robin, up to BURST beats per grant, registered output.
// One arbitration cycle per grant; m_ready low stalls the granted source and holds the output beat.
module data_inf_rr_arbiter
    import data_inf_arb_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM-1:0]         s_valid,
    input  logic [NUM*DSIZE-1:0]   s_data,
    output logic [NUM-1:0]         s_ready,
    output logic                   m_valid,
    output logic [DSIZE-1:0]       m_data,
    output logic [IDX_W(NUM)-1:0]  m_id,
    input  logic                   m_ready
);

    localparam int IW = IDX_W(NUM);
    localparam int CW = $clog2(BURST + 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_gnt;
    logic [CW-1:0]    r_cnt;
    logic             r_m_valid;
    logic [DSIZE-1:0] r_m_data;
    logic [IW-1:0]    r_m_id;

    logic             w_any;
    logic [IW-1:0]    w_pick;
    logic             w_gnt_vld;
    logic             w_gnt_rdy;
    logic             w_accept;
    logic             w_release;
    logic [IW-1:0]    w_gnt_inc;

    rr_pick #(
        .NUM (NUM)
    ) u_pick (
        .req (s_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    assign w_gnt_vld = s_valid[r_gnt];
    assign w_gnt_rdy = !r_m_valid || m_ready;
    assign w_gnt_inc = (r_gnt == IW'(NUM - 1)) ? '0 : r_gnt + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = '0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                s_ready[r_gnt] = w_gnt_rdy;
                w_accept       = w_gnt_vld && w_gnt_rdy;
                // A source that drops valid forfeits the remainder of its burst.
                if (!w_gnt_vld || (w_accept && r_cnt == CW'(BURST - 1))) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Nothing may be accepted in a reset cycle, whatever state we are leaving.
        if (rst) begin
            s_ready  = '0;
            w_accept = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_id    <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt <= w_pick;
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= s_data[r_gnt*DSIZE +: DSIZE];
                r_m_id    <= r_gnt;
                r_cnt     <= r_cnt + CW'(1);
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_release) begin
                r_ptr <= w_gnt_inc;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_id    = r_m_id;

endmodule

// File: tb/tb_data_inf_rr_arbiter.sv
// Bench for data_inf_rr_arbiter: vector table, directed corner sequences, random traffic vs a transaction model.
module tb_data_inf_rr_arbiter;

    localparam int NUM   = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;

    logic                 clock = 1'b0;
    logic                 rst;
    logic [NUM-1:0]       s_valid;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]       s_ready;
    logic                 m_valid;
    logic [DSIZE-1:0]     m_data;
    logic [1:0]           m_id;
    logic                 m_ready;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clock = ~clock;

    data_inf_rr_arbiter #(
        .NUM   (NUM),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_id    (m_id),
        .m_ready (m_ready)
    );

    // Reference model: who owns the output (-1 = nobody), beats taken, rotation start, output beat.
    int             md_owner;
    int             md_beats;
    int             md_ptr;
    bit             md_ov;
    logic [1:0]     md_oid;
    logic [7:0]     md_od;
    logic [NUM-1:0] acc_mask;
    logic [3:0]     seq [NUM];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [NUM-1:0] md_ready();
        logic [NUM-1:0] r;
        r = '0;
        if (!rst && md_owner >= 0) begin
            r[md_owner] = !md_ov || m_ready;
        end
        return r;
    endfunction

    task automatic md_tick();
        bit acc;
        acc = !rst && md_owner >= 0 && s_valid[md_owner] && (!md_ov || m_ready);
        if (rst) begin
            md_owner = -1; md_beats = 0; md_ptr = 0;
            md_ov = 0; md_oid = '0; md_od = '0;
            return;
        end
        if (acc) begin
            md_od  = s_data[md_owner*DSIZE +: DSIZE];
            md_oid = 2'(md_owner);
            md_ov  = 1;
            md_beats++;
        end else if (m_ready) begin
            md_ov = 0;
        end
        if (md_owner < 0) begin
            for (int k = 0; k < NUM; k++) begin
                if (md_owner < 0 && s_valid[(md_ptr + k) % NUM]) begin
                    md_owner = (md_ptr + k) % NUM;
                    md_beats = 0;
                end
            end
        end else if (!s_valid[md_owner] || (acc && md_beats == BURST)) begin
            md_ptr   = (md_owner + 1) % NUM;
            md_owner = -1;
        end
    endtask

    // Called right after inputs are driven on the falling edge.
    task automatic step();
        #1;
        chk("s_ready", 32'(s_ready), 32'(md_ready()));
        chk("m_valid", 32'(m_valid), 32'(md_ov));
        if (md_ov) begin
            chk("m_beat", {22'b0, m_id, m_data}, {22'b0, md_oid, md_od});
        end
        acc_mask = s_valid & s_ready;
        @(posedge clock);
        md_tick();
        @(negedge clock);
        for (int i = 0; i < NUM; i++) begin
            if (acc_mask[i]) seq[i] = seq[i] + 4'd1;
        end
    endtask

    typedef struct {
        bit             rst;
        logic [NUM-1:0] sv;
        bit             mr;
        logic [NUM-1:0] rdy;
        bit             mv;
        logic [1:0]     id;
    } vec_t;

    vec_t vt [27];

    initial begin
        md_owner = -1; md_beats = 0; md_ptr = 0;
        md_ov = 0; md_oid = '0; md_od = '0;
        for (int i = 0; i < NUM; i++) seq[i] = '0;

        // Reset + full-load rotation: arbitrate, 4 beats, bubble, next index.
        vt[0] = '{1, 4'hF, 1, 4'h0, 0, 2'd0};
        vt[1] = '{0, 4'hF, 1, 4'h0, 0, 2'd0};
        for (int g = 0; g < 5; g++) begin
            vt[2 + 5*g] = '{0, 4'hF, 1, 4'(1 << (g % 4)), 0, 2'd0};
            for (int b = 1; b < 4; b++) begin
                vt[2 + 5*g + b] = '{0, 4'hF, 1, 4'(1 << (g % 4)), 1, 2'(g % 4)};
            end
            vt[2 + 5*g + 4] = '{0, 4'hF, 1, 4'h0, 1, 2'(g % 4)};
        end

        rst = 1; s_valid = '1; s_data = '0; m_ready = 1;
        @(posedge clock);
        md_tick();
        @(negedge clock);

        for (int t = 0; t < 27; t++) begin
            rst = vt[t].rst; s_valid = vt[t].sv; m_ready = vt[t].mr;
            for (int i = 0; i < NUM; i++) s_data[i*DSIZE +: DSIZE] = {4'(i), seq[i]};
            #1;
            chk("tbl_s_ready", 32'(s_ready), 32'(vt[t].rdy));
            chk("tbl_m_valid", 32'(m_valid), 32'(vt[t].mv));
            if (vt[t].mv) chk("tbl_m_id", 32'(m_id), 32'(vt[t].id));
            step();
        end

        // Single requester 2 sends two beats then drops; then 0 and 3 race from ptr=3.
        rst = 1; s_valid = '0; s_data = '0; m_ready = 1; step();
        rst = 0; s_valid = 4'b0100; s_data[16 +: 8] = 8'hA1; step();
        #1; chk("r2_ready", 32'(s_ready), 32'h4); step();
        s_data[16 +: 8] = 8'hA2;
        #1; chk("r2_beat1", {m_id, m_data}, {2'd2, 8'hA1}); step();
        s_valid = 4'b0000;
        #1; chk("r2_beat2", {m_id, m_data}, {2'd2, 8'hA2}); chk("r2_ready_drop", 32'(s_ready), 32'h4); step();
        s_valid = 4'b1001;
        #1; chk("race_idle", 32'(s_ready), 32'h0); step();
        #1; chk("race_first3", 32'(s_ready), 32'h8); step();
        s_valid = 4'b0001; step();
        step();
        #1; chk("race_then0", 32'(s_ready), 32'h1); step();

        // Requester 1 stalled by m_ready low for 5 cycles after beat 0x55.
        rst = 1; s_valid = '0; m_ready = 1; step();
        rst = 0; s_valid = 4'b0010; s_data[8 +: 8] = 8'h55; step();
        #1; chk("bp_ready", 32'(s_ready), 32'h2); step();
        s_data[8 +: 8] = 8'h66; m_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_hold_data", {m_valid, m_id, m_data}, {1'b1, 2'd1, 8'h55});
            chk("bp_hold_ready", 32'(s_ready), 32'h0);
            step();
        end
        m_ready = 1;
        #1; chk("bp_resume", 32'(s_ready), 32'h2); step();
        s_data[8 +: 8] = 8'h77;
        #1; chk("bp_next", {m_id, m_data}, {2'd1, 8'h66}); step();
        s_data[8 +: 8] = 8'h88; step();
        s_data[8 +: 8] = 8'h99;
        #1; chk("bp_last", {m_id, m_data}, {2'd1, 8'h88}); chk("bp_burst_end", 32'(s_ready), 32'h0); step();

        // Reset pulse mid-burst with a beat in the output register.
        rst = 1; s_valid = '1; m_ready = 1; step();
        rst = 0; step(); step(); step();
        rst = 1;
        #1; chk("rst_ready", 32'(s_ready), 32'h0); step();
        rst = 0; s_valid = 4'b0110;
        #1; chk("rst_mvalid", 32'(m_valid), 32'h0); chk("rst_idle", 32'(s_ready), 32'h0); step();
        #1; chk("rst_lowest", 32'(s_ready), 32'h2); step();

        // Random traffic checked every cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            m_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(0, 3) == 0) s_valid[i] = ~s_valid[i];
            end
            s_data = NUM*DSIZE'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
